// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Latency WIDTH cycles after the accepting edge; start is ignored while busy.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             zero
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sa;
  logic [WIDTH-1:0] sb;
  logic [WIDTH-1:0] sr;
  logic             br;
  logic [CW-1:0]    cnt;

  logic             d;
  logic             br_next;
  logic [WIDTH-1:0] sr_next;

  always_comb begin
    d       = sa[0] ^ sb[0] ^ br;
    br_next = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & br);
    sr_next = {d, sr[WIDTH-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sa    <= '0;
      sb    <= '0;
      sr    <= '0;
      br    <= 1'b0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      diff  <= '0;
      bout  <= 1'b0;
      zero  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          // DONE accepts start too, giving back-to-back operation
          if (start) begin
            sa    <= a;
            sb    <= b;
            br    <= bin;
            sr    <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        RUN: begin
          sa  <= {1'b0, sa[WIDTH-1:1]};
          sb  <= {1'b0, sb[WIDTH-1:1]};
          sr  <= sr_next;
          br  <= br_next;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) begin
            diff  <= sr_next;
            bout  <= br_next;
            zero  <= (sr_next == '0);
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and randomised checks of serial_subtractor at WIDTH=8 and WIDTH=13.
module tb_serial_subtractor;

  logic        clk;
  logic        rst;

  logic        s8, bi8, busy8, done8, bout8, zero8;
  logic [7:0]  a8, b8, diff8;
  logic        s13, bi13, busy13, done13, bout13, zero13;
  logic [12:0] a13, b13, diff13;

  int total = 0;
  int bad   = 0;

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(s8), .a(a8), .b(b8), .bin(bi8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8), .zero(zero8)
  );

  serial_subtractor #(.WIDTH(13)) dut13 (
    .clk(clk), .rst(rst), .start(s13), .a(a13), .b(b13), .bin(bi13),
    .busy(busy13), .done(done13), .diff(diff13), .bout(bout13), .zero(zero13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after an accepting edge; returns edges until done is seen.
  task automatic wait_done(input bit w13, output int n, output int busy_cnt);
    n = 0;
    busy_cnt = 0;
    while (n < 40) begin
      @(negedge clk);
      if (w13 ? done13 : done8) break;
      if (w13 ? busy13 : busy8) busy_cnt++;
      @(posedge clk);
      n++;
    end
  endtask

  // Called at a negedge with the DUT idle.
  task automatic run_op(input bit w13, input logic [12:0] av, input logic [12:0] bv,
                        input logic bi, input logic [12:0] ed, input logic eb,
                        input string tag);
    int n, bc, w;
    w = w13 ? 13 : 8;
    if (w13) begin
      s13 = 1'b1; a13 = av; b13 = bv; bi13 = bi;
    end else begin
      s8 = 1'b1; a8 = av[7:0]; b8 = bv[7:0]; bi8 = bi;
    end
    @(posedge clk);
    #1 s8 = 1'b0; s13 = 1'b0;
    wait_done(w13, n, bc);
    check({tag, "_lat"}, n, w);
    check({tag, "_busy"}, bc, w);
    check({tag, "_diff"}, w13 ? diff13 : {5'b0, diff8}, ed);
    check({tag, "_bout"}, w13 ? bout13 : bout8, eb);
    check({tag, "_zero"}, w13 ? zero13 : zero8, ed == 13'd0);
    @(posedge clk);
    @(negedge clk);
    check({tag, "_pulse"}, w13 ? done13 : done8, 1'b0);
  endtask

  initial begin
    int n, bc, seen;
    logic [12:0] av, bv, ed;
    logic        bi;
    logic [13:0] r;

    rst = 1'b1;
    s8 = 0; a8 = 0; b8 = 0; bi8 = 0;
    s13 = 0; a13 = 0; b13 = 0; bi13 = 0;
    repeat (2) @(negedge clk);
    check("rst_busy", busy8, 1'b0);
    check("rst_done", done8, 1'b0);
    check("rst_diff", diff8, 8'h00);
    check("rst_bout", bout8, 1'b0);
    check("rst_zero", zero8, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_op(0, 13'h5A, 13'h3C, 0, 13'h1E, 0, "basic");
    run_op(0, 13'h00, 13'h01, 0, 13'hFF, 1, "under");
    run_op(0, 13'h10, 13'h0F, 1, 13'h00, 0, "zero");

    // start held high; operands change while running and must be ignored
    s8 = 1'b1; a8 = 8'h77; b8 = 8'h77; bi8 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 a8 = 8'h03; b8 = 8'h05;
    wait_done(0, n, bc);
    check("b2b1_lat", n, 7);
    check("b2b1_diff", diff8, 8'h00);
    check("b2b1_zero", zero8, 1'b1);
    check("b2b1_bout", bout8, 1'b0);
    @(posedge clk);
    #1 s8 = 1'b0;
    wait_done(0, n, bc);
    check("b2b2_lat", n, 8);
    check("b2b2_diff", diff8, 8'hFE);
    check("b2b2_bout", bout8, 1'b1);
    check("b2b2_zero", zero8, 1'b0);
    @(posedge clk);
    @(negedge clk);

    // asynchronous reset mid-operation
    s8 = 1'b1; a8 = 8'hF0; b8 = 8'h0F; bi8 = 1'b0;
    @(posedge clk);
    #1 s8 = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("arst_busy", busy8, 1'b0);
    check("arst_done", done8, 1'b0);
    check("arst_diff", diff8, 8'h00);
    check("arst_bout", bout8, 1'b0);
    check("arst_zero", zero8, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (done8 || busy8) seen++;
    end
    check("arst_quiet", seen, 0);
    run_op(0, 13'h0F, 13'h01, 0, 13'h0E, 0, "fresh");

    // randomised sweep against {bout,diff} = a - b - bin
    for (int i = 0; i < 600; i++) begin
      av = 13'($urandom_range(0, 255));
      bv = 13'($urandom_range(0, 255));
      bi = 1'($urandom_range(0, 1));
      if (i == 0) begin av = 13'hFF; bv = 13'hFF; bi = 1'b1; end
      r  = {1'b0, av} - {1'b0, bv} - {13'd0, bi};
      ed = {5'd0, r[7:0]};
      run_op(0, av, bv, bi, ed, r[8], "rand8");
    end
    for (int i = 0; i < 600; i++) begin
      av = 13'($urandom);
      bv = 13'($urandom);
      bi = 1'($urandom_range(0, 1));
      if (i == 0) begin av = 13'h1234; bv = 13'h1234; bi = 1'b0; end
      r  = {1'b0, av} - {1'b0, bv} - {13'd0, bi};
      run_op(1, av, bv, bi, r[12:0], r[13], "rand13");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial two's-complement/unsigned subtractor computing diff = a − b − bin, one bit per clock, LSB first.
- Sits beside the combinational adder datapath as the area-lean inverse operation for multi-cycle arithmetic.
- Uses a start/busy/done handshake and a registered borrow flop.
- Latency is WIDTH cycles.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while busy=0.
- a  input  WIDTH  minuend; captured on accepted start.
- b  input  WIDTH  subtrahend; captured on accepted start.
- bin  input  1  borrow-in; captured on accepted start.
- busy  output  1  high while a subtraction is in progress (state RUN).
- done  output  1  one-cycle pulse: result valid.
- diff  output  WIDTH  result (a − b − bin) mod 2^WIDTH; holds until the next completion.
- bout  output  1  borrow-out: 1 iff a < b + bin (unsigned).
- zero  output  1  1 iff diff == 0; updated with diff.

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-high.
- Reset (async, any time including mid-operation):
  - state=IDLE; busy=0, done=0, diff=0, bout=0, zero=0.
  - Internal shift registers, borrow flop and bit counter are cleared.
  - The in-flight operation is discarded.
- States:
  - IDLE: busy=0, done=0. If start=1 at the edge: load a→sa, b→sb, bin→br, cnt=0, go to RUN.
  - RUN: busy=1. Each edge processes one bit:
    - d = sa[0]^sb[0]^br
    - br ← (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br)
    - sa, sb shift right
    - d is shifted into the MSB of the internal result register sr
    - cnt++
    - When cnt==WIDTH−1 at the edge: diff ← final sr value including this bit; bout ← br_next; zero ← (final sr==0); go to DONE.
  - DONE: busy=0, done=1 for exactly one cycle.
    - start=1 at the edge: accepted, operands loaded, go to RUN (back-to-back).
    - Otherwise go to IDLE.
- Timing: start accepted at edge E0 → busy high from E0 through E0+WIDTH. diff, bout and zero change at E0+WIDTH, and done is high for the cycle following that edge.
- Handshake:
  - start during RUN is ignored, with no effect on the current operation.
  - a, b and bin are don't-care except at the accepting edge.
- Outputs:
  - diff, bout and zero never change during RUN; they show the previous result.
  - All outputs are registered; there are no combinational paths from inputs to outputs.
- Arithmetic:
  - Modulo 2^WIDTH; bout is the unsigned borrow out of the MSB.
  - For signed interpretation, diff is the correct two's-complement result; overflow is not reported.
- Counter width: $clog2(WIDTH). No wrap beyond WIDTH−1 is possible in RUN.

Test Plan:
- WIDTH=8, a=0x5A, b=0x3C, bin=0, start pulse → done exactly 8 cycles after accepting edge; diff=0x1E, bout=0, zero=0; busy high 8 cycles.
- a=0x00, b=0x01, bin=0 → diff=0xFF, bout=1, zero=0. Then a=0x10, b=0x0F, bin=1 → diff=0x00, bout=0, zero=1.
- a=0x77, b=0x77, bin=0; hold start=1 continuously with new operands a=0x03, b=0x05 presented from cycle 2 → second request ignored during RUN. First result diff=0x00, zero=1. Start on the done cycle is accepted back-to-back, giving diff=0xFE, bout=1, 8 cycles later.
- Start a=0xF0, b=0x0F; assert rst asynchronously at cycle 4 mid-RUN → all outputs 0 immediately, state IDLE. No done pulse follows. A fresh start a=0x0F, b=0x01 yields diff=0x0E.
- Randomised sweep (≥1000 vectors, WIDTH=8 and WIDTH=13) against reference model {bout,diff} = a − b − bin → exact match. done is a single-cycle pulse every time.
